// File: rtl/data_ram_arbiter_if.sv
// data_ram_arbiter_if: requester ports and memoriaRAM bus of the data RAM arbiter.
interface data_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  REQ0, REQ1, WE0, WE1, LOCK0, LOCK1;
    logic [ADDR_WIDTH-1:0] ADDR0, ADDR1;
    logic [DATA_WIDTH-1:0] WDATA0, WDATA1;
    logic                  GNT0, GNT1, RVALID0, RVALID1;
    logic [DATA_WIDTH-1:0] RDATA0, RDATA1;
    logic [ADDR_WIDTH-1:0] RAM_ADDRESS;
    logic                  RAM_MEM_WRITE;
    logic [DATA_WIDTH-1:0] RAM_WRITE_DATA, RAM_READ_DATA;
    modport slave (
        input  REQ0, REQ1, WE0, WE1, LOCK0, LOCK1, ADDR0, ADDR1, WDATA0, WDATA1, RAM_READ_DATA,
        output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, RAM_ADDRESS, RAM_MEM_WRITE, RAM_WRITE_DATA
    );
    modport master (
        output REQ0, REQ1, WE0, WE1, LOCK0, LOCK1, ADDR0, ADDR1, WDATA0, WDATA1, RAM_READ_DATA,
        input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, RAM_ADDRESS, RAM_MEM_WRITE, RAM_WRITE_DATA
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: round-robin arbiter with bounded lock bursts sharing memoriaRAM between MEM stage and loader.
// Define DATA_RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 first) in IDLE.
module data_ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input logic               CLK,
    input logic               RESET_N,
    data_ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic [3:0]            bcnt_q, bcnt_d, bnext;
    logic                  win0, win1, g0, g1;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        case (state_q)
            OWN0:    win0 = bus.REQ0;
            OWN1:    win1 = bus.REQ1;
            default: begin
`ifdef DATA_RAM_ARB_FIXED_PRIO_EN
                win0 = bus.REQ0;
                win1 = bus.REQ1 & ~bus.REQ0;
`else
                win0 = bus.REQ0 & (~bus.REQ1 | last_q);
                win1 = bus.REQ1 & (~bus.REQ0 | ~last_q);
`endif
            end
        endcase
    end

    // Grants are masked while in reset so no write can land on a reset edge.
    assign g0 = win0 & RESET_N;
    assign g1 = win1 & RESET_N;
    assign bnext = bcnt_q + 4'd1;

    assign bus.GNT0           = g0;
    assign bus.GNT1           = g1;
    assign bus.RAM_ADDRESS    = g0 ? bus.ADDR0 : g1 ? bus.ADDR1 : '0;
    assign bus.RAM_MEM_WRITE  = (g0 & bus.WE0) | (g1 & bus.WE1);
    assign bus.RAM_WRITE_DATA = g0 ? bus.WDATA0 : g1 ? bus.WDATA1 : '0;
    assign bus.RDATA0         = rdata0_q;
    assign bus.RDATA1         = rdata1_q;
    assign bus.RVALID0        = rvalid0_q;
    assign bus.RVALID1        = rvalid1_q;

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        last_d    = g1 ? 1'b1 : g0 ? 1'b0 : last_q;
        rvalid0_d = g0 & ~bus.WE0;
        rvalid1_d = g1 & ~bus.WE1;
        rdata0_d  = rvalid0_d ? bus.RAM_READ_DATA : rdata0_q;
        rdata1_d  = rvalid1_d ? bus.RAM_READ_DATA : rdata1_q;
        case (state_q)
            OWN0: begin
                state_d = (!g0 || !bus.LOCK0 || bnext >= 4'(MAX_BURST)) ? IDLE : OWN0;
                bcnt_d  = (state_d == IDLE) ? 4'd0 : bnext;
            end
            OWN1: begin
                state_d = (!g1 || !bus.LOCK1 || bnext >= 4'(MAX_BURST)) ? IDLE : OWN1;
                bcnt_d  = (state_d == IDLE) ? 4'd0 : bnext;
            end
            default: begin
                // A single-grant burst limit makes a lock meaningless, so stay in IDLE.
                if (MAX_BURST > 1 && ((g0 && bus.LOCK0) || (g1 && bus.LOCK1))) begin
                    state_d = g0 ? OWN0 : OWN1;
                    bcnt_d  = 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            bcnt_q    <= 4'd0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            bcnt_q    <= bcnt_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed checks of data_ram_arbiter against a behavioural memoriaRAM.
module tb_data_ram_arbiter;
`ifdef DATA_RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic CLK, RESET_N;
    int   checks, errors, wr_cnt;
    logic [31:0] mem [1024];

    data_ram_arbiter_if bus ();
    data_ram_arbiter dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // memoriaRAM: asynchronous read, synchronous write
    assign bus.RAM_READ_DATA = mem[bus.RAM_ADDRESS];
    initial wr_cnt = 0;
    always @(posedge CLK) begin
        if (bus.RAM_MEM_WRITE) begin
            mem[bus.RAM_ADDRESS] <= bus.RAM_WRITE_DATA;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic r0, w0, l0, input logic [9:0] a0, input logic [31:0] d0,
                       input logic r1, w1, l1, input logic [9:0] a1, input logic [31:0] d1);
        bus.REQ0 = r0; bus.WE0 = w0; bus.LOCK0 = l0; bus.ADDR0 = a0; bus.WDATA0 = d0;
        bus.REQ1 = r1; bus.WE1 = w1; bus.LOCK1 = l1; bus.ADDR1 = a1; bus.WDATA1 = d1;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        RESET_N = 1'b0;
        drv(1, 1, 0, 10'h3FF, 32'hDEAD, 1, 1, 0, 10'h3FE, 32'hBEEF);
        #2;
        chk("rst_gnt0", bus.GNT0, 0);
        chk("rst_gnt1", bus.GNT1, 0);
        chk("rst_memwr", bus.RAM_MEM_WRITE, 0);
        chk("rst_addr", bus.RAM_ADDRESS, 0);
        chk("rst_wdata", bus.RAM_WRITE_DATA, 0);
        chk("rst_rvalid", {bus.RVALID0, bus.RVALID1}, 0);
        chk("rst_rdata0", bus.RDATA0, 0);
        chk("rst_rdata1", bus.RDATA1, 0);
        tick;
        tick;
        chk("rst_no_write", wr_cnt, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 RESET_N = 1'b1;

        drv(1, 1, 0, 10'h16A, 32'hFFF, 0, 0, 0, 0, 0);
        #1;
        chk("wr_gnt0", bus.GNT0, 1);
        chk("wr_memwr", bus.RAM_MEM_WRITE, 1);
        chk("wr_addr", bus.RAM_ADDRESS, 10'h16A);
        chk("wr_wdata", bus.RAM_WRITE_DATA, 32'hFFF);
        tick;
        chk("wr_commit", mem[10'h16A], 32'hFFF);
        chk("wr_no_rvalid", bus.RVALID0, 0);
        drv(1, 0, 0, 10'h16A, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rd_gnt0", bus.GNT0, 1);
        chk("rd_memwr", bus.RAM_MEM_WRITE, 0);
        tick;
        chk("rd_rvalid0", bus.RVALID0, 1);
        chk("rd_rdata0", bus.RDATA0, 32'hFFF);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        chk("rd_rvalid_pulse", bus.RVALID0, 0);
        chk("rd_rdata_hold", bus.RDATA0, 32'hFFF);

        drv(1, 1, 0, 10'h000, 32'h18C, 0, 0, 0, 0, 0);
        tick;
        drv(0, 0, 0, 0, 0, 1, 1, 0, 10'h04B, 32'h643);
        #1;
        chk("pre_gnt1", bus.GNT1, 1);
        chk("pre_addr1", bus.RAM_ADDRESS, 10'h04B);
        tick;
        chk("pre_commit", mem[10'h04B], 32'h643);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RESET_N = 1'b0;
        #1 RESET_N = 1'b1;
        chk("rst2_rdata0", bus.RDATA0, 0);

        drv(1, 0, 0, 10'h000, 0, 1, 0, 0, 10'h04B, 0);
        for (int i = 0; i < 4; i++) begin
            logic e0;
            e0 = FIXED ? 1'b1 : (i % 2 == 0);
            #1;
            chk($sformatf("rr_gnt0_%0d", i), bus.GNT0, e0);
            chk($sformatf("rr_gnt1_%0d", i), bus.GNT1, !e0);
            tick;
            chk($sformatf("rr_rvalid_%0d", i), {bus.RVALID0, bus.RVALID1}, {e0, !e0});
            if (e0) chk($sformatf("rr_rdata0_%0d", i), bus.RDATA0, 32'h18C);
            else    chk($sformatf("rr_rdata1_%0d", i), bus.RDATA1, 32'h643);
        end

        drv(0, 0, 0, 10'h000, 0, 1, 0, 1, 10'h04B, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) bus.REQ0 = 1'b1;
            #1;
            chk($sformatf("burst_gnt1_%0d", i), bus.GNT1, i < 4);
            chk($sformatf("burst_gnt0_%0d", i), bus.GNT0, i == 4);
            tick;
        end

        drv(0, 0, 0, 10'h000, 0, 1, 0, 1, 10'h04B, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                bus.REQ0  = 1'b1;
                bus.LOCK1 = 1'b0;
            end
            #1;
            chk($sformatf("drop_gnt1_%0d", i), bus.GNT1, i < 2);
            chk($sformatf("drop_gnt0_%0d", i), bus.GNT0, i == 2);
            tick;
        end

        drv(0, 0, 0, 10'h000, 0, 1, 0, 1, 10'h04B, 0);
        #1;
        chk("mid_gnt1_c1", bus.GNT1, 1);
        tick;
        bus.REQ0 = 1'b1;
        #1;
        chk("mid_gnt1_c2", bus.GNT1, 1);
        chk("mid_rvalid1", bus.RVALID1, 1);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_gnt", {bus.GNT0, bus.GNT1}, 0);
        chk("mid_rst_rvalid1", bus.RVALID1, 0);
        chk("mid_rst_rdata1", bus.RDATA1, 0);
        chk("mid_rst_memwr", bus.RAM_MEM_WRITE, 0);
        tick;
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk("post_rst_gnt0", bus.GNT0, 1);
        chk("post_rst_gnt1", bus.GNT1, 0);
        tick;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
